ikari_linebuf_sched: RTL and testbench

Sequencer for the front-layer ping-pong sprite line buffer: accepts sprite strip write commands from the sprite fetcher, streams strip pixels into the write bank with transparency skip, and reads out the display bank with clear-after-read. It swaps banks on every line latch and sits between the sprite fetch logic and the two 512×8 line RAMs, producing the line-buffer pixel stream for the video mixer.

---
 rtl/ikari_linebuf_sched.sv | 184 ++++++++++++++++++
 tb/tb_ikari_linebuf_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ikari_linebuf_sched.sv
// rtl/ikari_linebuf_sched.sv - ping-pong sprite line-buffer sequencer (strip write, clear-after-read readout)
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   cen                 pixel clock enable (never high on two consecutive clks)
//   line_start          line latch pulse: swaps banks, aborts strip, loads read start
//   hstart_x, inv_n     read start address and direction (1 = up, 0 = down)
//   req_valid/ready/x   strip command handshake and start write address
//   px_data, px_pop     strip pixel input and its consume strobe
//   b0_*, b1_*          the two line RAMs: address, write enable, write data, read data
//   wr_bank             bank currently written; the other bank is displayed
//   pix_out, pix_valid  line-buffer pixel stream toward the video mixer

module ikari_linebuf_sched #(
    parameter int AW        = 9,
    parameter int DW        = 8,
    parameter int STRIP_LEN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          line_start,
    input  logic [AW-1:0] hstart_x,
    input  logic          inv_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_x,
    input  logic [DW-1:0] px_data,
    output logic          px_pop,
    output logic [AW-1:0] b0_addr,
    output logic [AW-1:0] b1_addr,
    output logic          b0_we,
    output logic          b1_we,
    output logic [DW-1:0] b0_din,
    output logic [DW-1:0] b1_din,
    input  logic [DW-1:0] b0_q,
    input  logic [DW-1:0] b1_q,
    output logic          wr_bank,
    output logic [DW-1:0] pix_out,
    output logic          pix_valid
);

    localparam int CW = $clog2(STRIP_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] wr_addr_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_addr_q;
    logic          clr_pend;
    logic          rd_cen;

    // Write-bank and display-bank operations before they are steered to b0/b1.
    logic [AW-1:0] wb_addr;
    logic          wb_we;
    logic [DW-1:0] wb_din;
    logic [AW-1:0] db_addr;
    logic          db_we;
    logic [DW-1:0] db_din;
    logic [DW-1:0] db_q;

    // ------------------------------------------------------------------
    // Strip write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr_addr <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            wr_addr <= wr_addr_nx;
            cnt     <= cnt_nx;
        end
    end

    // line_start overrides everything: the strip in flight is dropped and no
    // command is taken on the latch clk, so the new line starts clean.
    always_comb begin
        state_nx   = state;
        wr_addr_nx = wr_addr;
        cnt_nx     = cnt;
        req_ready  = 1'b0;
        px_pop     = 1'b0;
        if (line_start) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        state_nx   = WRITE;
                        wr_addr_nx = req_x;
                        cnt_nx     = '0;
                    end
                end
                WRITE: begin
                    if (cen) begin
                        px_pop     = 1'b1;
                        wr_addr_nx = wr_addr + 1'b1;
                        cnt_nx     = cnt + 1'b1;
                        if (cnt == CW'(STRIP_LEN - 1)) begin
                            state_nx = IDLE;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Pixels whose low three bits are all ones are transparent and leave the
    // line buffer untouched. Write data is held at zero when nothing is popped.
    assign wb_addr = wr_addr;
    assign wb_we   = px_pop & (px_data[2:0] != 3'b111);
    assign wb_din  = px_pop ? px_data : '0;

    // ------------------------------------------------------------------
    // Display readout with clear-after-read
    // ------------------------------------------------------------------
    assign rd_cen = cen & ~line_start;
    assign db_q   = wr_bank ? b0_q : b1_q;

    // Because cen is never high on back-to-back clks, the clear clk that
    // follows a read never collides with the next read, so one RAM port per
    // bank is enough for read and clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank   <= 1'b0;
            rd_addr   <= '0;
            rd_addr_q <= '0;
            clr_pend  <= 1'b0;
            pix_out   <= {DW{1'b1}};
            pix_valid <= 1'b0;
        end else begin
            clr_pend  <= rd_cen;
            pix_valid <= clr_pend;
            if (clr_pend) begin
                pix_out <= db_q;
            end
            if (line_start) begin
                wr_bank <= ~wr_bank;
                rd_addr <= hstart_x;
            end else if (cen) begin
                rd_addr_q <= rd_addr;
                rd_addr   <= inv_n ? rd_addr + 1'b1 : rd_addr - 1'b1;
            end
        end
    end

    assign db_addr = clr_pend ? rd_addr_q : rd_addr;
    assign db_we   = clr_pend;
    assign db_din  = clr_pend ? {DW{1'b1}} : '0;

    // ------------------------------------------------------------------
    // Bank steering
    // ------------------------------------------------------------------
    always_comb begin
        b0_addr = wb_addr;
        b0_we   = wb_we;
        b0_din  = wb_din;
        b1_addr = db_addr;
        b1_we   = db_we;
        b1_din  = db_din;
        if (wr_bank) begin
            b0_addr = db_addr;
            b0_we   = db_we;
            b0_din  = db_din;
            b1_addr = wb_addr;
            b1_we   = wb_we;
            b1_din  = wb_din;
        end
    end

endmodule

// File: tb/tb_ikari_linebuf_sched.sv
// tb/tb_ikari_linebuf_sched.sv - scoreboard bench for ikari_linebuf_sched with line-RAM models

module tb_ikari_linebuf_sched;

    localparam int AW = 9;
    localparam int DW = 8;
    localparam int SL = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cen;
    logic          line_start;
    logic [AW-1:0] hstart_x;
    logic          inv_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_x;
    logic [DW-1:0] px_data;
    logic          px_pop;
    logic [AW-1:0] b0_addr;
    logic [AW-1:0] b1_addr;
    logic          b0_we;
    logic          b1_we;
    logic [DW-1:0] b0_din;
    logic [DW-1:0] b1_din;
    logic [DW-1:0] b0_q;
    logic [DW-1:0] b1_q;
    logic          wr_bank;
    logic [DW-1:0] pix_out;
    logic          pix_valid;

    ikari_linebuf_sched #(.AW(AW), .DW(DW), .STRIP_LEN(SL)) dut (
        .clk(clk), .rst(rst), .cen(cen), .line_start(line_start),
        .hstart_x(hstart_x), .inv_n(inv_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
        .px_data(px_data), .px_pop(px_pop),
        .b0_addr(b0_addr), .b1_addr(b1_addr), .b0_we(b0_we), .b1_we(b1_we),
        .b0_din(b0_din), .b1_din(b1_din), .b0_q(b0_q), .b1_q(b1_q),
        .wr_bank(wr_bank), .pix_out(pix_out), .pix_valid(pix_valid)
    );

    always #5 clk = ~clk;

    // Line RAM models: synchronous read, read-before-write.
    logic [DW-1:0] mem0 [512];
    logic [DW-1:0] mem1 [512];
    always @(posedge clk) begin
        if (b0_we) mem0[b0_addr] <= b0_din;
        b0_q <= mem0[b0_addr];
        if (b1_we) mem1[b1_addr] <= b1_din;
        b1_q <= mem1[b1_addr];
    end

    // Reference: line contents per bank, plus expected event queues.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wev_t;

    logic [DW-1:0] ref_mem [2][512];
    wev_t          wq0 [$];
    wev_t          wq1 [$];
    logic [DW-1:0] pq  [$];

    int errors = 0;
    int checks = 0;
    int pop_cnt = 0;

    bit            m_active;
    int            m_idx;
    logic [AW-1:0] m_waddr;
    logic [AW-1:0] m_rd;
    logic [AW-1:0] m_clr_addr;
    bit            m_wb;
    bit            m_clr_pend;
    bit            last_cen;
    logic [DW-1:0] strip      [SL];
    logic [DW-1:0] next_strip [SL];

    bit exp_ready = 1'b1;
    bit exp_pop   = 1'b0;
    bit exp_wb    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_we(input bit b, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wev_t e;
        e.addr = a;
        e.data = d;
        if (b) wq1.push_back(e);
        else   wq0.push_back(e);
    endtask

    task automatic mon_we(input bit b, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wev_t e;
        checks++;
        if ((b ? wq1.size() : wq0.size()) == 0) begin
            errors++;
            $display("FAIL bank%0d_write: got write [%0h]<=%0h expected none", b, a, d);
        end else begin
            e = b ? wq1.pop_front() : wq0.pop_front();
            if (e.addr !== a || e.data !== d) begin
                errors++;
                $display("FAIL bank%0d_write: got [%0h]<=%0h expected [%0h]<=%0h", b, a, d, e.addr, e.data);
            end
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", req_ready, 1);
            chk("rst_pix_out", pix_out, 8'hFF);
            chk("rst_wr_bank", wr_bank, 0);
            chk("rst_we", {b0_we, b1_we}, 0);
            chk("rst_px_pop", px_pop, 0);
            chk("rst_pix_valid", pix_valid, 0);
            chk("rst_addr_din", {b0_addr, b1_addr, b0_din, b1_din}, 0);
        end else begin
            chk("req_ready", req_ready, exp_ready);
            chk("px_pop", px_pop, exp_pop);
            chk("wr_bank", wr_bank, exp_wb);
            if (px_pop) pop_cnt++;
            if (b0_we) mon_we(1'b0, b0_addr, b0_din);
            if (b1_we) mon_we(1'b1, b1_addr, b1_din);
            if (pix_valid) begin
                if (pq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_out: got pixel %0h expected no pixel", pix_out);
                end else begin
                    chk("pix_out", pix_out, pq.pop_front());
                end
            end
        end
    end

    // One clk of stimulus; the model advances by the line-buffer rules.
    task automatic cyc(input bit c, input bit l, input bit v, input logic [AW-1:0] x,
                       input logic [AW-1:0] h, input bit i);
        bit acc;
        bit pop;
        bit db;
        if (last_cen) c = 1'b0;
        last_cen   = c;
        cen        = c;
        line_start = l;
        req_valid  = v;
        req_x      = x;
        hstart_x   = h;
        inv_n      = i;
        px_data    = m_active ? strip[m_idx] : 8'($urandom);
        exp_wb     = m_wb;
        exp_ready  = !m_active && !l;
        acc        = exp_ready && v;
        pop        = m_active && c && !l;
        exp_pop    = pop;
        db         = !m_wb;
        if (m_clr_pend) begin
            push_we(db, m_clr_addr, 8'hFF);
            ref_mem[db][m_clr_addr] = 8'hFF;
            m_clr_pend = 1'b0;
        end
        if (pop) begin
            if (strip[m_idx][2:0] != 3'b111) begin
                push_we(m_wb, m_waddr, strip[m_idx]);
                ref_mem[m_wb][m_waddr] = strip[m_idx];
            end
            m_waddr = m_waddr + 9'd1;
            m_idx++;
            if (m_idx == SL) m_active = 1'b0;
        end
        if (c && !l) begin
            pq.push_back(ref_mem[db][m_rd]);
            m_clr_pend = 1'b1;
            m_clr_addr = m_rd;
            m_rd       = i ? m_rd + 9'd1 : m_rd - 9'd1;
        end
        if (l) begin
            m_wb     = !m_wb;
            m_active = 1'b0;
            m_rd     = h;
        end
        if (acc) begin
            m_active = 1'b1;
            m_idx    = 0;
            m_waddr  = x;
            for (int k = 0; k < SL; k++) strip[k] = next_strip[k];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit i);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 9'($urandom), 9'($urandom), i);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        pq.delete();
        wq0.delete();
        wq1.delete();
        m_active   = 1'b0;
        m_idx      = 0;
        m_wb       = 1'b0;
        m_rd       = '0;
        m_waddr    = '0;
        m_clr_pend = 1'b0;
        exp_ready  = 1'b1;
        exp_pop    = 1'b0;
        exp_wb     = 1'b0;
        for (int k = 0; k < n; k++) begin
            cen        = (k % 2 == 0);
            line_start = 1'b0;
            req_valid  = 1'b1;
            req_x      = 9'($urandom);
            px_data    = 8'($urandom);
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        cen      = 1'b0;
        last_cen = 1'b0;
    endtask

    task automatic rand_strip();
        for (int k = 0; k < SL; k++)
            next_strip[k] = ($urandom_range(3) == 0) ? 8'({5'($urandom), 3'b111}) : 8'($urandom);
    endtask

    int p0;

    initial begin
        rst = 1'b1; cen = 1'b0; line_start = 1'b0; req_valid = 1'b0;
        req_x = '0; hstart_x = '0; inv_n = 1'b1; px_data = '0; last_cen = 1'b0;
        for (int a = 0; a < 512; a++) begin
            mem0[a] = 8'hFF; mem1[a] = 8'hFF;
            ref_mem[0][a] = 8'hFF; ref_mem[1][a] = 8'hFF;
        end
        do_reset(3);

        // Single strip at 0x020 into bank 0.
        for (int k = 0; k < SL; k++) next_strip[k] = 8'(8'h10 + k);
        p0 = pop_cnt;
        cyc(1'b1, 1'b0, 1'b1, 9'h020, 9'h000, 1'b1);
        run(40, 1'b1);
        chk("strip_pops", pop_cnt - p0, 16);
        chk("strip_mem_020", mem0[9'h020], 8'h10);
        chk("strip_mem_02a", mem0[9'h02A], 8'h1A);
        chk("strip_skip_027", mem0[9'h027], 8'hFF);
        chk("strip_skip_02f", mem0[9'h02F], 8'hFF);

        // Swap and forward readout from 0x020.
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 9'h020, 1'b1);
        run(40, 1'b1);
        chk("swap_wr_bank", wr_bank, 1);
        chk("cleared_020", mem0[9'h020], 8'hFF);
        chk("cleared_02e", mem0[9'h02E], 8'hFF);

        // Wrapping strip at 0x1FA into bank 1, then descending readout through 0.
        for (int k = 0; k < SL; k++) next_strip[k] = 8'(8'h40 + k);
        cyc(1'b1, 1'b0, 1'b1, 9'h1FA, 9'h000, 1'b1);
        run(40, 1'b1);
        chk("wrap_mem_1fa", mem1[9'h1FA], 8'h40);
        chk("wrap_mem_1ff", mem1[9'h1FF], 8'h45);
        chk("wrap_mem_000", mem1[9'h000], 8'h46);
        chk("wrap_mem_008", mem1[9'h008], 8'h4E);
        chk("wrap_skip_001", mem1[9'h001], 8'hFF);
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 9'h004, 1'b0);
        run(40, 1'b0);
        chk("rev_cleared_1ff", mem1[9'h1FF], 8'hFF);
        chk("rev_cleared_000", mem1[9'h000], 8'hFF);

        // Abort after 5 pops, with a competing command on the latch clk.
        rand_strip();
        p0 = pop_cnt;
        cyc(1'b0, 1'b0, 1'b1, 9'h100, 9'h000, 1'b1);
        for (int k = 0; k < 20 && m_idx < 5; k++) cyc(1'b1, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 9'h150, 9'h100, 1'b1);
        chk("abort_pops", pop_cnt - p0, 5);
        p0 = pop_cnt;
        run(20, 1'b1);
        chk("abort_no_more_pops", pop_cnt - p0, 0);

        // Reset in the middle of a strip.
        rand_strip();
        cyc(1'b0, 1'b0, 1'b1, 9'h0C0, 9'h000, 1'b1);
        run(6, 1'b1);
        do_reset(3);
        run(10, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset(2);
            if (!m_active) rand_strip();
            cyc(1'($urandom_range(1)), $urandom_range(59) == 0, $urandom_range(3) == 0,
                9'($urandom), 9'($urandom), 1'($urandom_range(1)));
        end

        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1);
        chk("drain_pix_queue", pq.size(), 0);
        chk("drain_bank0_writes", wq0.size(), 0);
        chk("drain_bank1_writes", wq1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
